icache: RTL and testbench

Direct-mapped, 16-frame, one-word-per-block instruction cache. It is the responder on the datapath side of `datapath_cache_if`: it answers the fetch stage's `imemREN`/`imemaddr` requests with `ihit`/`imemload`. On a miss it acts as the initiator toward the memory controller (`iREN`/`iaddr`, answered by `iwait`/`iload`). It sits between the pipelined datapath's PC/fetch logic and the memory controller.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/icache.sv | 125 ++++++++++++
 tb/tb_icache.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Holds the instruction-cache address view (tag/idx/byte-offset split),
// its field widths, and the cache controller state encoding.
package cpu_types_pkg;

    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;

    // Byte address as seen by the instruction cache.
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   halt                 datapath halted: no new fill may start
//   imemREN, imemaddr    fetch request from the datapath
//   ihit, imemload       combinational hit and instruction word
//   iREN, iaddr          read request toward the memory controller
//   iwait, iload         memory busy flag and read data
//   hit_count            saturating count of hit cycles
//   miss_count           saturating count of fills started
//
// NFRAMES must equal 2**IIDX_W because the frame index is taken straight
// from the idx field of the address.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    icache_state_t     state, next_state;
    icachef_t          raddr;
    icachef_t          maddr;

    logic [NFRAMES-1:0] valid;
    logic [ITAG_W-1:0]  tags [NFRAMES];
    logic [31:0]        data [NFRAMES];

    logic [31:0] hit_cnt, miss_cnt;
    logic        hit, start_fill, fill_done;

    // The byte offset never takes part in a lookup.
    logic unused_bytoff;
    assign unused_bytoff = ^raddr.bytoff;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign raddr = icachef_t'(imemaddr);

    // Lookup is combinational and suppressed while a fill is outstanding.
    assign hit = imemREN && valid[raddr.idx] && (tags[raddr.idx] == raddr.tag)
                 && (state == IDLE);

    assign ihit       = hit;
    assign imemload   = hit ? data[raddr.idx] : 32'h0;
    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;

    always_comb begin
        next_state = state;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        case (state)
            IDLE: begin
                if (imemREN && !hit && !halt) begin
                    start_fill = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = maddr;
                // The fill targets maddr regardless of redirects or halt.
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            maddr    <= '0;
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            state <= next_state;
            if (start_fill) begin
                maddr    <= '{tag: raddr.tag, idx: raddr.idx, bytoff: 2'b00};
                miss_cnt <= sat_inc(miss_cnt);
            end
            if (hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
        end
    end

    // Frame storage lives in flops so reset can invalidate every frame,
    // including one whose fill was cut short.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
            for (int i = 0; i < NFRAMES; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else if (fill_done) begin
            valid[maddr.idx] <= 1'b1;
            tags[maddr.idx]  <= maddr.tag;
            data[maddr.idx]  <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        halt = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr, hit_count, miss_count;

    icache #(.NFRAMES(16)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload),
        .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h8C00_0000 | (a << 10);
    endfunction

    // Memory controller: holds iwait high for 'lat' cycles of each request.
    int lat = 2;
    int mwait = 0;
    always @(posedge CLK) begin
        #1;
        if (!nRST || !iREN) begin
            mwait = 0;
            iwait = 1'b1;
            iload = 32'h0;
        end else if (mwait < lat) begin
            iwait = 1'b1;
            mwait++;
        end else begin
            iwait = 1'b0;
            iload = memword(iaddr);
        end
    end

    // Reference model: which word-line each slot holds, whether a fill is
    // outstanding, and plain event counts.
    bit          m_busy;
    logic [29:0] m_pend;
    bit          m_valid [16];
    logic [29:0] m_line  [16];
    logic [31:0] m_data  [16];
    longint      m_hits, m_miss;
    logic [29:0] c_line;
    int          c_slot;
    bit          c_hit;
    logic [31:0] c_load, c_iaddr;

    always @(negedge CLK) begin
        if (!nRST) begin
            m_busy = 0; m_pend = '0; m_hits = 0; m_miss = 0;
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            chk("rst_ihit", {31'b0, ihit}, 32'h0);
            chk("rst_imemload", imemload, 32'h0);
            chk("rst_iREN", {31'b0, iREN}, 32'h0);
            chk("rst_iaddr", iaddr, 32'h0);
            chk("rst_hit_count", hit_count, 32'h0);
            chk("rst_miss_count", miss_count, 32'h0);
        end else begin
            c_line  = imemaddr[31:2];
            c_slot  = int'(c_line % 16);
            c_hit   = !m_busy && imemREN && m_valid[c_slot] && (m_line[c_slot] == c_line);
            c_load  = c_hit ? m_data[c_slot] : 32'h0;
            c_iaddr = m_busy ? {m_pend, 2'b00} : 32'h0;
            chk("ihit", {31'b0, ihit}, {31'b0, c_hit});
            chk("imemload", imemload, c_load);
            chk("iREN", {31'b0, iREN}, {31'b0, m_busy});
            chk("iaddr", iaddr, c_iaddr);
            chk("hit_count", hit_count, m_hits[31:0]);
            chk("miss_count", miss_count, m_miss[31:0]);
            if (m_busy) begin
                if (!iwait) begin
                    m_valid[m_pend % 16] = 1;
                    m_line[m_pend % 16]  = m_pend;
                    m_data[m_pend % 16]  = iload;
                    m_busy = 0;
                end
            end else if (imemREN && !c_hit && !halt) begin
                m_busy = 1;
                m_pend = c_line;
                if (m_miss < 64'hFFFF_FFFF) m_miss++;
            end
            if (c_hit && m_hits < 64'hFFFF_FFFF) m_hits++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_hit(input string name);
        int i = 0;
        while (!ihit && i < 30) begin
            step(1);
            i++;
        end
        chk(name, {31'b0, ihit}, 32'h1);
    endtask

    task automatic wait_fill(input string name);
        int i = 0;
        while (iREN && i < 30) begin
            step(1);
            i++;
        end
        chk(name, {31'b0, iREN}, 32'h0);
    endtask

    int nren;

    initial begin
        step(2);
        nRST = 1'b1;
        step(1);

        // Cold miss with two wait cycles
        lat = 2;
        imemREN = 1'b1;
        imemaddr = 32'h0000_0040;
        nren = 0;
        for (int i = 0; i < 20 && !ihit; i++) begin
            if (iREN) nren++;
            step(1);
        end
        chk("cold_ren_cycles", nren, 32'd3);
        chk("cold_ihit", {31'b0, ihit}, 32'h1);
        chk("cold_load", imemload, 32'h8C01_0000);
        chk("cold_miss_count", miss_count, 32'd1);

        // Four hit cycles
        step(4);
        chk("hits_after_4", hit_count, 32'd4);
        chk("hit_still", {31'b0, ihit}, 32'h1);

        // Conflict: same idx, different tag
        imemaddr = 32'h0000_0080;
        #1;
        chk("conflict_miss", {31'b0, ihit}, 32'h0);
        wait_hit("conflict_fill");
        chk("conflict_load", imemload, 32'h8C02_0000);
        chk("conflict_miss_count", miss_count, 32'd2);
        imemaddr = 32'h0000_0040;
        #1;
        chk("evicted_miss", {31'b0, ihit}, 32'h0);
        wait_hit("evicted_refill");
        chk("evicted_miss_count", miss_count, 32'd3);

        // Redirect during fill
        imemaddr = 32'h0000_0100;
        step(1);
        chk("redir_fetch", iaddr, 32'h0000_0100);
        imemaddr = 32'h0000_0200;
        wait_fill("redir_fill_done");
        imemaddr = 32'h0000_0100;
        #1;
        chk("redir_old_hit", {31'b0, ihit}, 32'h1);
        chk("redir_old_load", imemload, 32'h8C04_0000);
        imemaddr = 32'h0000_0200;
        #1;
        chk("redir_new_miss", {31'b0, ihit}, 32'h0);
        wait_hit("redir_new_fill");
        chk("redir_new_load", imemload, 32'h8C08_0000);
        chk("redir_miss_count", miss_count, 32'd5);

        // Halt blocks a new fill
        halt = 1'b1;
        imemaddr = 32'h0000_0040;
        step(3);
        chk("halt_iren", {31'b0, iREN}, 32'h0);
        chk("halt_miss_count", miss_count, 32'd5);
        halt = 1'b0;
        step(1);
        chk("halt_release_iren", {31'b0, iREN}, 32'h1);
        halt = 1'b1;
        wait_fill("halt_mid_fill_done");
        chk("halt_mid_hit", {31'b0, ihit}, 32'h1);
        chk("halt_mid_load", imemload, 32'h8C01_0000);
        chk("halt_mid_miss_count", miss_count, 32'd6);
        halt = 1'b0;

        // Reset in the middle of a fill
        lat = 5;
        imemaddr = 32'h0000_0300;
        step(2);
        chk("rstmid_in_fetch", {31'b0, iREN}, 32'h1);
        nRST = 1'b0;
        #1;
        chk("rstmid_iren_drop", {31'b0, iREN}, 32'h0);
        chk("rstmid_iaddr_drop", iaddr, 32'h0);
        step(1);
        nRST = 1'b1;
        lat = 0;
        imemaddr = 32'h0000_0040;
        #1;
        chk("rstmid_invalidated", {31'b0, ihit}, 32'h0);
        wait_hit("rstmid_refill");
        chk("rstmid_miss_count", miss_count, 32'd1);

        // Saturation of hit_count
        imemREN = 1'b0;
        step(1);
        dut.hit_cnt = 32'hFFFF_FFFE;
        m_hits = 64'hFFFF_FFFE;
        imemREN = 1'b1;
        step(3);
        chk("sat_hit_count", hit_count, 32'hFFFF_FFFF);
        imemREN = 1'b0;
        step(2);
        chk("idle_no_hit", {31'b0, ihit}, 32'h0);
        chk("idle_hit_count", hit_count, 32'hFFFF_FFFF);
        chk("idle_miss_count", miss_count, 32'd1);

        step(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
